rv_alu_md_unit: RTL and testbench

//  Parametrised successor to the single-cycle RV32I ALU. Executes base integer ops plus RV M-extension MUL/DIV/REM.

---
 rtl/rv_alu_md_unit_pkg.sv | 43 ++++
 rtl/rv_alu_md_unit_if.sv | 28 ++
 rtl/rv_alu_md_unit_muldiv.sv | 127 ++++++++++++
 rtl/rv_alu_md_unit.sv | 120 ++++++++++++
 tb/tb_rv_alu_md_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_alu_md_unit_pkg.sv
// Shared op codes, FSM state encoding and operand-signedness helpers for the
// execute-stage ALU with iterative multiply/divide.
package rv_alu_md_unit_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLL    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_SLT    = 5'b01000;
  localparam logic [4:0] OP_SLTU   = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic op_signed_a(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv_alu_md_unit_if.sv
// Issue/result handshake bundle between the execute stage and the ALU/mul-div unit.
interface rv_alu_md_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             kill;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output kill, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_tag
  );

  modport slave (
    input  kill, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_tag
  );
endinterface

// File: rtl/rv_alu_md_unit_muldiv.sv
// Shared 1-bit-per-cycle datapath: shift-add multiply and restoring divide on
// operand magnitudes, with the sign fix-up applied to the final step's value.
module rv_alu_md_unit_muldiv
  import rv_alu_md_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic              busy_r;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   acc_r;
  logic [XLEN-1:0]   lo_r;
  logic [XLEN-1:0]   dsr_r;
  logic [XLEN-1:0]   a_r;
  logic [4:0]        op_r;
  logic              neg_a_r;
  logic              neg_b_r;
  logic              bzero_r;

  logic              sgn_a_s;
  logic              sgn_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN:0]     sum_s;
  logic [XLEN:0]     diff_s;
  logic [XLEN-1:0]   acc_nxt_s;
  logic [XLEN-1:0]   lo_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;

  assign sgn_a_s = op_signed_a(op) & a[XLEN-1];
  assign sgn_b_s = op_signed_b(op) & b[XLEN-1];
  assign mag_a_s = sgn_a_s ? ({XLEN{1'b0}} - a) : a;
  assign mag_b_s = sgn_b_s ? ({XLEN{1'b0}} - b) : b;
  assign done    = busy_r & (cnt_r == {CW{1'b0}});

  // One iteration: {acc,lo} is the product shift register or the remainder/quotient pair
  always_comb begin
    sum_s     = {1'b0, acc_r} + (lo_r[0] ? {1'b0, dsr_r} : {(XLEN+1){1'b0}});
    diff_s    = {acc_r, lo_r[XLEN-1]} - {1'b0, dsr_r};
    acc_nxt_s = sum_s[XLEN:1];
    lo_nxt_s  = {sum_s[0], lo_r[XLEN-1:1]};
    if (op_r[2]) begin
      if (!diff_s[XLEN]) begin
        acc_nxt_s = diff_s[XLEN-1:0];
        lo_nxt_s  = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {acc_r[XLEN-2:0], lo_r[XLEN-1]};
        lo_nxt_s  = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = sum_s[XLEN:1];
      lo_nxt_s  = {sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override on the post-step value
  always_comb begin
    prod_s = {acc_nxt_s, lo_nxt_s};
    if (neg_a_r ^ neg_b_r) begin
      prod_s = {(2*XLEN){1'b0}} - {acc_nxt_s, lo_nxt_s};
    end else begin
      prod_s = {acc_nxt_s, lo_nxt_s};
    end
    quot_s = bzero_r ? {XLEN{1'b1}} :
             ((neg_a_r ^ neg_b_r) ? ({XLEN{1'b0}} - lo_nxt_s) : lo_nxt_s);
    rem_s  = bzero_r ? a_r :
             (neg_a_r ? ({XLEN{1'b0}} - acc_nxt_s) : acc_nxt_s);
    case (op_r)
      OP_MUL:                        result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quot_s;
      OP_REM, OP_REMU:               result = rem_s;
      default:                       result = {XLEN{1'b0}};
    endcase
  end

  // Operand load on start, then XLEN steps counted down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {XLEN{1'b0}};
      lo_r    <= {XLEN{1'b0}};
      dsr_r   <= {XLEN{1'b0}};
      a_r     <= {XLEN{1'b0}};
      op_r    <= 5'b00000;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
      bzero_r <= 1'b0;
    end else if (abort) begin
      busy_r <= 1'b0;
    end else if (start) begin
      busy_r  <= 1'b1;
      cnt_r   <= CW'(XLEN - 1);
      acc_r   <= {XLEN{1'b0}};
      lo_r    <= mag_a_s;
      dsr_r   <= mag_b_s;
      a_r     <= a;
      op_r    <= op;
      neg_a_r <= sgn_a_s;
      neg_b_r <= sgn_b_s;
      bzero_r <= (b == {XLEN{1'b0}});
    end else if (busy_r) begin
      acc_r <= acc_nxt_s;
      lo_r  <= lo_nxt_s;
      if (done) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/rv_alu_md_unit.sv
// Execute-stage ALU: single-cycle base integer ops plus iterative MUL/DIV/REM,
// one op in flight, valid/ready on both sides, flushable by kill.
module rv_alu_md_unit
  import rv_alu_md_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  rv_alu_md_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_e           state_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_result_r;
  logic             out_zero_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [TAG_W-1:0] busy_tag_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             md_start_s;
  logic             md_done_s;
  logic [XLEN-1:0]  md_result_s;
  logic [XLEN-1:0]  base_result_s;
  logic [SHW-1:0]   shamt_s;

  assign in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_DONE) & bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign md_start_s = accept_s & is_muldiv(bus.in_op) & ~bus.kill;
  assign shamt_s    = bus.in_b[SHW-1:0];

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_zero   = out_zero_r;
  assign bus.out_tag    = out_tag_r;

  rv_alu_md_unit_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .abort  (bus.kill),
    .start  (md_start_s),
    .op     (bus.in_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .done   (md_done_s),
    .result (md_result_s)
  );

  // Single-cycle base operations; unknown codes produce zero
  always_comb begin
    base_result_s = {XLEN{1'b0}};
    case (bus.in_op)
      OP_ADD:  base_result_s = bus.in_a + bus.in_b;
      OP_SUB:  base_result_s = bus.in_a - bus.in_b;
      OP_AND:  base_result_s = bus.in_a & bus.in_b;
      OP_OR:   base_result_s = bus.in_a | bus.in_b;
      OP_XOR:  base_result_s = bus.in_a ^ bus.in_b;
      OP_SLL:  base_result_s = bus.in_a << shamt_s;
      OP_SRL:  base_result_s = bus.in_a >> shamt_s;
      OP_SRA:  base_result_s = $signed(bus.in_a) >>> shamt_s;
      OP_SLT:  base_result_s = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      OP_SLTU: base_result_s = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
      default: base_result_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM; rst beats kill, kill beats every handshake event
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
      out_zero_r   <= 1'b1;
      out_tag_r    <= {TAG_W{1'b0}};
      busy_tag_r   <= {TAG_W{1'b0}};
    end else if (bus.kill) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            if (is_muldiv(bus.in_op)) begin
              state_r     <= ST_BUSY;
              out_valid_r <= 1'b0;
              busy_tag_r  <= bus.in_tag;
            end else begin
              state_r      <= ST_DONE;
              out_valid_r  <= 1'b1;
              out_result_r <= base_result_s;
              out_zero_r   <= (base_result_s == {XLEN{1'b0}});
              out_tag_r    <= bus.in_tag;
            end
          end else if ((state_r == ST_DONE) && bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (md_done_s) begin
            state_r      <= ST_DONE;
            out_valid_r  <= 1'b1;
            out_result_r <= md_result_s;
            out_zero_r   <= (md_result_s == {XLEN{1'b0}});
            out_tag_r    <= busy_tag_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu_md_unit.sv
// Scoreboard bench: directed and random ops against an arithmetic reference model,
// plus latency, backpressure, kill and mid-op reset scenarios.
module tb_rv_alu_md_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [4:0] C_ADD = 5'h00, C_SUB = 5'h01, C_AND = 5'h02, C_OR = 5'h03;
  localparam logic [4:0] C_XOR = 5'h04, C_SLL = 5'h05, C_SRL = 5'h06, C_SRA = 5'h07;
  localparam logic [4:0] C_SLT = 5'h08, C_SLTU = 5'h09;
  localparam logic [4:0] C_MUL = 5'h10, C_MULH = 5'h11, C_MULHSU = 5'h12, C_MULHU = 5'h13;
  localparam logic [4:0] C_DIV = 5'h14, C_DIVU = 5'h15, C_REM = 5'h16, C_REMU = 5'h17;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rv_alu_md_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  rv_alu_md_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = 32'h0;
    case (op)
      C_ADD:    r = a + b;
      C_SUB:    r = a - b;
      C_AND:    r = a & b;
      C_OR:     r = a | b;
      C_XOR:    r = a ^ b;
      C_SLL:    r = a << b[4:0];
      C_SRL:    r = a >> b[4:0];
      C_SRA:    r = $signed(a) >>> b[4:0];
      C_SLT:    r = (sa < sb) ? 32'h1 : 32'h0;
      C_SLTU:   r = (a < b) ? 32'h1 : 32'h0;
      C_MUL:    begin p = sa * sb; r = p[31:0]; end
      C_MULH:   begin p = sa * sb; r = p[63:32]; end
      C_MULHSU: begin p = sa * ub; r = p[63:32]; end
      C_MULHU:  begin p = ua * ub; r = p[63:32]; end
      C_DIV: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      C_DIVU:   r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      C_REM: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      C_REMU:   r = (b == 32'h0) ? a : a % b;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; optionally queue its expected result and measure its latency
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res,
                       input bit push, input bit wait_res);
    int   w;
    int   lat;
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'h1);
    if (push) begin
      e.res = res;
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (wait_res) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.out_valid && lat < 100);
      check("latency", 64'(lat), (op[4:3] == 2'b10) ? 64'd33 : 64'd1);
    end
  endtask

  // Scoreboard monitor: every completed handshake must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got result %h tag %h, required none", bus.out_result, bus.out_tag);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(bus.out_result), 64'(e.res));
        check("zero",   64'(bus.out_zero),   64'(e.res == 32'h0));
        check("tag",    64'(bus.out_tag),    64'(e.tag));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        dir[18];
    logic [4:0]  op_tab[20];
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_tag;
    int          seen;

    dir = '{
      '{C_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
      '{C_SUB,    32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
      '{C_SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
      '{C_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
      '{C_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
      '{C_SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
      '{5'h1F,    32'h0000_0001, 32'h0000_0002, 32'h0000_0000},
      '{C_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{C_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
      '{C_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
      '{C_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{C_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
      '{C_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF},
      '{C_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007},
      '{C_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{C_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{C_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF},
      '{C_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9}
    };
    op_tab = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLL, C_SRL, C_SRA, C_SLT, C_SLTU,
               C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU,
               5'h0F, 5'h1C};

    rst           = 1'b1;
    bus.kill      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 5'h0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.in_tag    = 5'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid",  64'(bus.out_valid),  64'h0);
    check("rst_out_result", 64'(bus.out_result), 64'h0);
    check("rst_out_zero",   64'(bus.out_zero),   64'h1);
    check("rst_out_tag",    64'(bus.out_tag),    64'h0);
    check("rst_in_ready",   64'(bus.in_ready),   64'h1);

    for (int i = 0; i < 18; i++) begin
      do_op(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), dir[i].res, 1'b1, 1'b1);
    end

    for (int i = 0; i < 80; i++) begin
      r_op  = op_tab[$urandom_range(0, 19)];
      r_a   = pick_operand();
      r_b   = pick_operand();
      r_tag = 5'($urandom);
      do_op(r_op, r_a, r_b, r_tag, model(r_op, r_a, r_b), 1'b1, 1'b1);
    end

    // Backpressure: result held, no new accept, then simultaneous drain + issue
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    do_op(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0A, 32'hFFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid",    64'(bus.out_valid),  64'h1);
      check("hold_result",   64'(bus.out_result), 64'hFFFF_FFFE);
      check("hold_tag",      64'(bus.out_tag),    64'h0A);
      check("hold_in_ready", 64'(bus.in_ready),   64'h0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_op     = C_ADD;
    bus.in_a      = 32'h0000_0010;
    bus.in_b      = 32'h0000_0020;
    bus.in_tag    = 5'h0B;
    bus.in_valid  = 1'b1;
    exp_q.push_back('{res: 32'h0000_0030, tag: 5'h0B});
    @(negedge clk);
    check("b2b_in_ready", 64'(bus.in_ready), 64'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_latency", 64'(bus.out_valid), 64'h1);

    // kill during BUSY drops the op
    do_op(C_DIVU, 32'h0000_1234, 32'h0000_0003, 5'h0C, 32'h0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    @(negedge clk);
    check("kill_in_ready",  64'(bus.in_ready),  64'h1);
    check("kill_out_valid", 64'(bus.out_valid), 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("kill_no_output", 64'(seen), 64'h0);

    // kill together with an accept drops the new op
    @(posedge clk);
    #1;
    bus.in_op    = C_ADD;
    bus.in_a     = 32'h1;
    bus.in_b     = 32'h1;
    bus.in_valid = 1'b1;
    bus.kill     = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.kill     = 1'b0;
    @(negedge clk);
    check("kill_accept_valid", 64'(bus.out_valid), 64'h0);

    // reset mid-BUSY drops the op and restores reset outputs
    do_op(C_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'h0D, 32'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid",  64'(bus.out_valid),  64'h0);
    check("rst2_out_result", 64'(bus.out_result), 64'h0);
    check("rst2_out_zero",   64'(bus.out_zero),   64'h1);
    check("rst2_out_tag",    64'(bus.out_tag),    64'h0);
    check("rst2_in_ready",   64'(bus.in_ready),   64'h1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst2_no_output", 64'(seen), 64'h0);
    do_op(C_ADD, 32'h0000_0003, 32'h0000_0004, 5'h0E, 32'h0000_0007, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
